// File: rtl/sc_et_ctrl.sv
// Run controller for one SNG: accepts a job, clears/loads the SNG, runs it for 2^k cycles
// (or until sng_done) and returns the AND-popcount. Optional rescale: define SC_ET_SCALE_EN.
module sc_et_ctrl #(
   parameter int unsigned W    = 6,
   parameter int unsigned N    = 2,
   parameter int unsigned NC   = 1,
   parameter int unsigned CORR = 0,
   parameter int unsigned TW   = (CORR != 0) ? W + NC : W * N + NC,
   parameter int unsigned LW   = $clog2(TW + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N*W-1:0]    in_bxs,
   input  logic [LW-1:0]     in_k,
   output logic              sng_clr,
   output logic              sng_en,
   output logic [N*W-1:0]    sng_bxs,
   input  logic [N-1:0]      sng_xs,
   input  logic              sng_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TW:0]       out_count,
   output logic [TW:0]       out_cycles,
   output logic [TW:0]       out_est,
   output logic              out_trunc
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StResult} state_e;

   state_e           state_q, state_d;
   logic [N*W-1:0]   bxs_q, bxs_d;
   logic [LW-1:0]    k_q, k_d;
   logic [TW:0]      count_q, count_d;
   logic [TW:0]      cycles_q, cycles_d;
   logic [TW:0]      est_q, est_d;
   logic             trunc_q, trunc_d;

   logic [TW:0]      count_inc;
   logic [TW:0]      cycles_inc;
   logic [TW:0]      limit;
   logic [TW:0]      est_final;
   logic             hit;
   logic             load;

   assign count_inc  = count_q + {{TW{1'b0}}, &sng_xs};
   assign cycles_inc = cycles_q + {{TW{1'b0}}, 1'b1};
   assign limit      = {{TW{1'b0}}, 1'b1} << k_q;
   assign hit        = (cycles_inc == limit);

`ifdef SC_ET_SCALE_EN
   logic [LW-1:0] shamt;
   assign shamt     = LW'(TW) - k_q;
   assign est_final = count_inc << shamt;
`else
   assign est_final = count_inc;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         bxs_q    <= '0;
         k_q      <= '0;
         count_q  <= '0;
         cycles_q <= '0;
         est_q    <= '0;
         trunc_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         bxs_q    <= bxs_d;
         k_q      <= k_d;
         count_q  <= count_d;
         cycles_q <= cycles_d;
         est_q    <= est_d;
         trunc_q  <= trunc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bxs_d     = bxs_q;
      k_d       = k_q;
      count_d   = count_q;
      cycles_d  = cycles_q;
      est_d     = est_q;
      trunc_d   = trunc_q;
      in_ready  = 1'b0;
      sng_en    = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               bxs_d   = in_bxs;
               k_d     = (in_k > LW'(TW)) ? LW'(TW) : in_k;
               state_d = StLoad;
            end
         end
         StLoad: begin
            load     = 1'b1;
            count_d  = '0;
            cycles_d = '0;
            est_d    = '0;
            trunc_d  = 1'b0;
            state_d  = StRun;
         end
         StRun: begin
            sng_en   = 1'b1;
            count_d  = count_inc;
            cycles_d = cycles_inc;
            // Final cycle is still sampled; reaching the limit wins over a coincident done.
            if (hit || sng_done) begin
               trunc_d = ~hit;
               est_d   = est_final;
               state_d = StResult;
            end
         end
         StResult: begin
            out_valid = 1'b1;
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign sng_clr    = rst | load;
   assign sng_bxs    = bxs_q;
   assign out_count  = count_q;
   assign out_cycles = cycles_q;
   assign out_est    = est_q;
   assign out_trunc  = trunc_q;

endmodule

// File: tb/tb_sc_et_ctrl.sv
// Directed bench for sc_et_ctrl with a behavioural SNG stub; follows SC_ET_SCALE_EN if defined.
module tb_sc_et_ctrl;

   localparam int TW = 13;
`ifdef SC_ET_SCALE_EN
   localparam bit SCALE = 1'b1;
`else
   localparam bit SCALE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [3:0]  in_k = '0;
   logic [11:0] in_bxs = '0;
   logic        in_ready, sng_clr, sng_en, sng_done, out_valid, out_trunc;
   logic [1:0]  sng_xs;
   logic [11:0] sng_bxs;
   logic [13:0] out_count, out_cycles, out_est;

   int total = 0;
   int bad = 0;
   int mode = 0;     // 0: xs=11, 1: alternate 11/01, 2: xs=00
   int done_at = 0;  // 1-based RUN cycle carrying sng_done, 0 = never
   int run_idx = 0;  // RUN cycles seen since last clear

   sc_et_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_bxs     (in_bxs),
      .in_k       (in_k),
      .sng_clr    (sng_clr),
      .sng_en     (sng_en),
      .sng_bxs    (sng_bxs),
      .sng_xs     (sng_xs),
      .sng_done   (sng_done),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_count  (out_count),
      .out_cycles (out_cycles),
      .out_est    (out_est),
      .out_trunc  (out_trunc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sng_clr) run_idx <= 0;
      else if (sng_en) run_idx <= run_idx + 1;
   end

   always_comb begin
      sng_xs = 2'b00;
      if (mode == 0) sng_xs = 2'b11;
      else if (mode == 1) sng_xs = (run_idx % 2 == 1) ? 2'b01 : 2'b11;
      sng_done = (done_at != 0) && (run_idx + 1 == done_at);
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_job(input logic [3:0] k, input int md, input int da, input logic [11:0] bxs,
                          input int ec, input int ecy, input bit etr);
      int kk;
      int lat;
      int exp_lat;
      longint exp_est;
      kk      = (int'(k) > TW) ? TW : int'(k);
      exp_lat = etr ? da + 2 : (1 << kk) + 2;
      exp_est = SCALE ? (longint'(ec) << (TW - kk)) : longint'(ec);
      mode    = md;
      done_at = da;
      @(negedge clk);
      check("job_in_ready", longint'(in_ready), 1);
      in_valid = 1'b1;
      in_k     = k;
      in_bxs   = bxs;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      check("load_clr", longint'({sng_clr, sng_en}), 2);
      while (!out_valid && lat < 9000) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, exp_lat);
      check("count", out_count, ec);
      check("cycles", out_cycles, ecy);
      check("trunc", longint'(out_trunc), longint'(etr));
      check("est", out_est, exp_est);
      check("en_cycles", run_idx, ecy);
      check("bxs", sng_bxs, bxs);
      check("busy_ready", longint'(in_ready), 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_hs", longint'({out_valid, in_ready}), 1);
   endtask

   typedef struct {
      logic [3:0]  k;
      int          md;
      int          da;
      logic [11:0] bxs;
      int          ec;
      int          ecy;
      bit          etr;
   } vec_t;

   vec_t vecs[7];
   bit   seen;
   int   guard;

   initial begin
      vecs[0] = '{k: 4'd4,  md: 0, da: 0, bxs: 12'hA5C, ec: 16,   ecy: 16,   etr: 1'b0};
      vecs[1] = '{k: 4'd4,  md: 1, da: 0, bxs: 12'h3F1, ec: 8,    ecy: 16,   etr: 1'b0};
      vecs[2] = '{k: 4'd6,  md: 0, da: 5, bxs: 12'h081, ec: 5,    ecy: 5,    etr: 1'b1};
      vecs[3] = '{k: 4'd15, md: 0, da: 0, bxs: 12'hFFF, ec: 8192, ecy: 8192, etr: 1'b0};
      vecs[4] = '{k: 4'd0,  md: 0, da: 0, bxs: 12'h001, ec: 1,    ecy: 1,    etr: 1'b0};
      vecs[5] = '{k: 4'd3,  md: 0, da: 8, bxs: 12'h5A5, ec: 8,    ecy: 8,    etr: 1'b0};
      vecs[6] = '{k: 4'd5,  md: 2, da: 0, bxs: 12'h777, ec: 0,    ecy: 32,   etr: 1'b0};

      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", longint'({in_ready, out_valid, sng_en, sng_clr}), 4'b1001);
      check("rst_results", longint'({out_count, out_cycles, out_est, out_trunc}), 0);
      check("rst_bxs", sng_bxs, 0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         run_job(vecs[i].k, vecs[i].md, vecs[i].da, vecs[i].bxs, vecs[i].ec, vecs[i].ecy,
                 vecs[i].etr);

      // Backpressure: result held while a second job is offered.
      mode = 0;
      done_at = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_k     = 4'd2;
      in_bxs   = 12'h123;
      @(posedge clk);
      @(negedge clk);
      in_bxs = 12'hEDC;
      guard = 0;
      while (!out_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("bp_count", out_count, 4);
      for (int i = 0; i < 10; i++) begin
         check("bp_hold", longint'({out_valid, in_ready, sng_en, out_count, sng_bxs}),
               longint'({1'b1, 1'b0, 1'b0, 14'd4, 12'h123}));
         @(negedge clk);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_release", longint'({out_valid, in_ready}), 1);
      check("bp_no_accept", sng_bxs, 12'h123);

      // Reset in the middle of a run.
      in_valid = 1'b1;
      in_k     = 4'd5;
      in_bxs   = 12'h0F0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      guard = 0;
      while (!(sng_en && run_idx == 2) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("mid_run_reached", run_idx, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_ctrl", longint'({in_ready, sng_en, out_valid}), 3'b100);
      check("mid_rst_results", longint'({out_count, out_cycles}), 0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (out_valid) seen = 1'b1;
         @(negedge clk);
      end
      check("mid_rst_no_result", longint'(seen), 0);
      run_job(4'd4, 0, 0, 12'h2B6, 16, 16, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sc_et_ctrl.md
# sc_et_ctrl

Run controller for one stochastic-number-generator (SNG) instance with early termination. It accepts an operand job over a valid/ready handshake, clears and loads the SNG, and enables it for exactly 2^k cycles, where k is supplied per job. It counts the ones in the AND of the SNG output bits (an SC multiply) and returns the count, optionally rescaled to full-stream length. It sits between the job source and the SNG, one controller per SNG.

## Interface
Parameters:
- W, 6, operand bit width
- N, 2, number of SNG output streams / operands
- NC, 1, SNG constant-stream bits
- CORR, 0, 1 = SNG shares one RNS group (TW = W+NC), 0 = independent groups (TW = W*N+NC)
- TW, derived, full stream length exponent; full run is 2^TW cycles
- LW, derived, $clog2(TW+1), width of the run-length exponent

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  job offered
- in_ready  out  1  controller idle and accepting
- in_bxs  in  N*W  operand words, operand i at [i*W +: W]
- in_k  in  LW  run-length exponent; values > TW clamp to TW
- sng_clr  out  1  active-high SNG clear/load strobe
- sng_en  out  1  SNG advance enable
- sng_bxs  out  N*W  registered operands driven to the SNG
- sng_xs  in  N  SNG output bits for the current cycle
- sng_done  in  1  SNG reports its sequence exhausted
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_count  out  TW+1  ones counted in AND(sng_xs)
- out_cycles  out  TW+1  cycles actually sampled
- out_est  out  TW+1  estimate (see Configuration)
- out_trunc  out  1  run ended by sng_done before 2^k cycles

## Operation
- FSM states: IDLE, LOAD, RUN, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_bxs into sng_bxs and k=min(in_k,TW), then go to LOAD.
- LOAD (1 cycle):
  - sng_clr=1, sng_en=0.
  - Clear the count, cycle counter and trunc flag.
  - Go to RUN.
- RUN:
  - sng_en=1.
  - Each cycle: cycles+=1; count+=&sng_xs.
  - Leave for RESULT after the cycle where cycles reaches 2^k, or after any cycle with sng_done=1.
  - In the sng_done case, that cycle is still sampled. out_trunc=1 if cycles<2^k at that point.
  - If the limit and sng_done land on the same cycle, out_trunc=0.
- RESULT:
  - out_valid=1. Outputs are registered and stable until handshake.
  - On out_valid&out_ready, go to IDLE.
- Widths: counters are TW+1 bits. count ≤ cycles ≤ 2^TW, so there is no overflow or wrap.
- in_valid is ignored outside IDLE. No job overlap; the next job is accepted only after the result handshake.
- sng_xs and sng_done are ignored outside RUN.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, sng_clr=1 while rst is high, sng_en=0.
  - sng_bxs=0, out_valid=0, out_count=0, out_cycles=0, out_est=0, out_trunc=0.
- Accept on edge T:
  - LOAD during T+1.
  - RUN during T+2 … T+1+2^k.
  - out_valid=1 from T+2+2^k. Latency from accept to result is 2^k+2 cycles.
- Result handshake on edge R: out_valid=0 and in_ready=1 from R+1.
- Reset asserted in any state (including mid-RUN) returns to IDLE on the next edge with all reset values. A partial result is never presented.

## Configuration
- Macro SC_ET_SCALE_EN.
  - Defined: out_est = out_count << (TW-k), the full-length-equivalent estimate.
    - For a truncated run, the same shift by (TW-k) is used; there is no re-normalisation.
    - A barrel shifter over TW+1 bits is instantiated.
  - Undefined: out_est = out_count, and no shifter is built.
- All other behaviour is identical in both builds.

## Test plan
Default params give TW=13. The bench uses a behavioural SNG stub.
- Reset: rst=1 for 2 cycles → in_ready=1, out_valid=0, sng_en=0, sng_clr=1, all result outputs 0.
- k=4, sng_xs held 2'b11:
  - out_valid at accept+18, out_count=16, out_cycles=16, out_trunc=0.
  - out_est=8192 with SC_ET_SCALE_EN, 16 without.
- k=4, sng_xs alternating 2'b11/2'b01 → out_count=8, out_est=4096 (scaled build); sng_en high for exactly 16 cycles.
- k=6, sng_done pulsed on RUN cycle 5, sng_xs=2'b11 → out_cycles=5, out_count=5, out_trunc=1. in_k=15 → clamped to k=13, run is 8192 cycles.
- Backpressure: out_ready low for 10 cycles with in_valid high → outputs stable, in_ready=0, no new job accepted. out_ready=1 → in_ready=1 next cycle.
- rst pulsed at RUN cycle 3 → IDLE next cycle, out_valid never asserted. A following job runs normally with the count starting from 0.
